// File: rtl/tail_sequencer.sv
// Fetch-path instruction assembler: decodes the head byte's opcode nibble into a length,
// gathers the tail bytes into one word and hands it to execute over valid/ready.
module tail_sequencer #(
  parameter int DW     = 8,
  parameter int MAXLEN = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [DW-1:0]        in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [DW*MAXLEN-1:0] out_insn,
  output logic [2:0]           out_len,
  output logic                 out_illegal,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy
);

  // state | meaning
  // HEAD  | waiting for the opcode byte of the next instruction
  // TAIL  | collecting tail bytes until cnt reaches the decoded length
  // OUT   | assembled instruction presented, waiting for out_ready
  typedef enum logic [1:0] {HEAD, TAIL, OUT} state_t;

  state_t                 r_state, w_next;
  logic [1:0]             r_cnt;
  logic [2:0]             r_len;
  logic [DW*MAXLEN-1:0]   r_insn;
  logic [2:0]             r_out_len;
  logic                   r_illegal;
  logic [2:0]             w_dec_len;
  logic [2:0]             w_cnt_inc;
  logic                   w_last;

  always_comb begin
    w_dec_len = 3'd0;
    if (in_data[1:0] == 2'b00)                        w_dec_len = 3'd1;
    else if (in_data[3] && !in_data[1])               w_dec_len = 3'd1;
    else if (in_data[3:0] == 4'b0001)                 w_dec_len = 3'd2;
    else if (in_data[3:0] == 4'b0010)                 w_dec_len = 3'd3;
    else if (in_data[3:0] == 4'b0011)                 w_dec_len = 3'd4;
  end

  assign w_cnt_inc = {1'b0, r_cnt} + 3'd1;
  assign w_last    = (w_cnt_inc == r_len);

  always_comb begin
    w_next = r_state;
    case (r_state)
      HEAD: if (in_valid) w_next = (w_dec_len <= 3'd1) ? OUT : TAIL;
      TAIL: if (in_valid && w_last) w_next = OUT;
      OUT:  if (out_ready) w_next = HEAD;
      default: w_next = HEAD;
    endcase
    if (flush) w_next = HEAD;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= HEAD;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= 2'd0;
      r_len     <= 3'd0;
      r_insn    <= '0;
      r_out_len <= 3'd0;
      r_illegal <= 1'b0;
    end else if (flush) begin
      r_cnt     <= 2'd0;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        HEAD: if (in_valid) begin
          r_insn    <= {{(DW*(MAXLEN-1)){1'b0}}, in_data};
          r_len     <= w_dec_len;
          r_illegal <= (w_dec_len == 3'd0);
          if (w_dec_len <= 3'd1) r_out_len <= 3'd1;
          else                   r_cnt     <= 2'd1;
        end
        TAIL: if (in_valid) begin
          // tail bytes are stored raw; their opcode nibble is irrelevant
          r_insn[DW*r_cnt +: DW] <= in_data;
          r_cnt                  <= w_cnt_inc[1:0];
          if (w_last) r_out_len <= r_len;
        end
        default: ;
      endcase
    end
  end

  assign in_ready    = (r_state != OUT);
  assign out_valid   = (r_state == OUT);
  assign busy        = (r_state != HEAD);
  assign out_insn    = r_insn;
  assign out_len     = r_out_len;
  assign out_illegal = r_illegal;

endmodule

// File: tb/tb_tail_sequencer.sv
// Directed bench for tail_sequencer with a scoreboard of expected instructions.
module tb_tail_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out_insn;
  logic [2:0]  out_len;
  logic        out_illegal;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        busy;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] insn;
    logic [2:0]  len;
    logic        ill;
  } exp_t;

  exp_t sb[$];

  tail_sequencer #(.DW(8), .MAXLEN(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_insn(out_insn), .out_len(out_len), .out_illegal(out_illegal),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] ref_len(input logic [3:0] ir);
    casez (ir)
      4'b??00: ref_len = 3'd1;
      4'b1?0?: ref_len = 3'd1;
      4'b0001: ref_len = 3'd2;
      4'b0010: ref_len = 3'd3;
      4'b0011: ref_len = 3'd4;
      default: ref_len = 3'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic put(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Pushes the expected result, then drives the bytes the decoder will consume.
  task automatic send_insn(input logic [7:0] b0, b1, b2, b3);
    exp_t        e;
    logic [2:0]  l;
    int          n;
    logic [31:0] w;
    l = ref_len(b0[3:0]);
    n = (l == 3'd0) ? 1 : int'(l);
    w = {b3, b2, b1, b0};
    for (int i = n; i < 4; i++) w[8*i +: 8] = 8'h00;
    e.insn = w;
    e.len  = (l == 3'd0) ? 3'd1 : l;
    e.ill  = (l == 3'd0);
    sb.push_back(e);
    put(b0);
    if (n > 1) put(b1);
    if (n > 2) put(b2);
    if (n > 3) put(b3);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    int   t;
    t = 0;
    while (out_valid !== 1'b1 && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_insn"}, out_insn, e.insn);
      chk({tag, "_len"}, {29'd0, out_len}, {29'd0, e.len});
      chk({tag, "_ill"}, {31'd0, out_illegal}, {31'd0, e.ill});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_drop"}, {30'd0, out_valid, busy}, 32'd0);
  endtask

  initial begin
    logic [31:0] held;
    #1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_insn", out_insn, 32'd0);
    chk("rst_len", {29'd0, out_len}, 32'd0);
    chk("rst_ready_busy", {30'd0, in_ready, busy}, 32'd2);
    chk("rst_ill", {31'd0, out_illegal}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: single-byte head
    send_insn(8'h04, 8'h00, 8'h00, 8'h00);
    chk("t1_latency", {31'd0, out_valid}, 32'd1);
    pop_check("t1");

    // 2: four-byte instruction, back-to-back bytes
    put(8'h03); put(8'hAA); put(8'hBB);
    chk("t2_not_yet", {30'd0, out_valid, busy}, 32'd1);
    sb.push_back('{insn: 32'hCCBBAA03, len: 3'd4, ill: 1'b0});
    put(8'hCC);
    chk("t2_latency", {31'd0, out_valid}, 32'd1);
    pop_check("t2");

    // 3: illegal head consumes one byte, next byte is a fresh head
    send_insn(8'h05, 8'h01, 8'h77, 8'h00);
    pop_check("t3a");
    send_insn(8'h01, 8'h77, 8'h00, 8'h00);
    pop_check("t3b");

    // tails that look like opcodes are not decoded; bubbles between bytes
    send_insn(8'h03, 8'h05, 8'h06, 8'h07);
    pop_check("tail_raw");
    put(8'h02);
    repeat (3) @(posedge clk);
    #1;
    chk("bubble_busy", {31'd0, busy}, 32'd1);
    put(8'h9E);
    repeat (2) @(posedge clk);
    #1;
    sb.push_back('{insn: 32'h00F09E02, len: 3'd3, ill: 1'b0});
    put(8'hF0);
    pop_check("bubble");

    // 4: backpressure in OUT
    send_insn(8'h08, 8'h00, 8'h00, 8'h00);
    held = out_insn;
    in_valid = 1'b1;
    in_data  = 8'h01;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("t4_in_ready", {31'd0, in_ready}, 32'd0);
      chk("t4_stable", out_insn, held);
    end
    in_valid = 1'b0;
    pop_check("t4");

    // 5: flush mid-TAIL drops the partial instruction and the flush-cycle byte
    put(8'h02); put(8'h11);
    flush = 1'b1; in_valid = 1'b1; in_data = 8'h33;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("t5_flush", {29'd0, out_valid, busy, out_illegal}, 32'd0);
    send_insn(8'h08, 8'h00, 8'h00, 8'h00);
    pop_check("t5");

    // 6: async reset mid-TAIL and in OUT
    put(8'h03); put(8'hAA);
    rst = 1'b1; #1;
    chk("t6a_rst", {29'd0, out_valid, busy, in_ready}, 32'd1);
    chk("t6a_insn", out_insn, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    put(8'h04);
    chk("t6b_pre", {31'd0, out_valid}, 32'd1);
    rst = 1'b1; #1;
    chk("t6b_rst", {29'd0, out_valid, busy, in_ready}, 32'd1);
    chk("t6b_len", {29'd0, out_len}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    send_insn(8'h01, 8'h5A, 8'h00, 8'h00);
    pop_check("t6c");

    chk("sb_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
